uart_ascii_line_receiver: RTL and testbench

//  Source side of the scrolling ASCII display path. Receives 8N1 UART bytes on
//  rx and assembles printable characters into a NUM_DIGITS-character line.
//  On CR/LF it hands the completed line to the display through

---
 rtl/uart_ascii_line_receiver.sv | 135 +++++++++++++
 tb/tb_uart_ascii_line_receiver.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_ascii_line_receiver.sv
// 8N1 UART receiver feeding a NUM_DIGITS-character line assembler; CR/LF commits
// the line to the scrolling display with a one-cycle latchNewString pulse.
module uart_ascii_line_receiver #(
    parameter int CLK_HZ               = 50_000_000,
    parameter int BAUD                 = 115_200,
    parameter int NUM_DIGITS           = 10,
    parameter int BITS_PER_ASCII_DIGIT = 8,
    parameter int BUF_BITS             = NUM_DIGITS * BITS_PER_ASCII_DIGIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    output logic [BUF_BITS-1:0] asciiStringToDisplay,
    output logic                needToScroll,
    output logic                latchNewString,
    output logic                frameError
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int NW           = $clog2(NUM_DIGITS + 1);
    localparam int CH           = BITS_PER_ASCII_DIGIT;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} rxState_t;

    rxState_t            state, nextState;
    logic                rxMeta, rxs;
    logic [CW-1:0]       baudCnt;
    logic [2:0]          bitCnt;
    logic [7:0]          shiftReg;
    logic                halfTick, bitTick;
    logic                clrBaud, shiftBit, byteValid, stopLow;
    logic [BUF_BITS-1:0] lineBuf;
    logic [NW-1:0]       count;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxs    <= rxMeta;
        end
    end

    assign halfTick = (baudCnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign bitTick  = (baudCnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!rxs) nextState = START;
            START:   if (halfTick) nextState = rxs ? IDLE : DATA;
            DATA:    if (bitTick && bitCnt == 3'd7) nextState = STOP;
            STOP:    if (bitTick) nextState = rxs ? IDLE : WAITHI;
            WAITHI:  if (rxs) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        clrBaud   = 1'b0;
        shiftBit  = 1'b0;
        byteValid = 1'b0;
        stopLow   = 1'b0;
        case (state)
            IDLE:    clrBaud = 1'b1;
            START:   clrBaud = halfTick;
            DATA: begin
                clrBaud  = bitTick;
                shiftBit = bitTick;
            end
            STOP: begin
                clrBaud   = bitTick;
                byteValid = bitTick && rxs;
                stopLow   = bitTick && !rxs;
            end
            WAITHI:  clrBaud = 1'b1;
            default: clrBaud = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else begin
            baudCnt <= clrBaud ? '0 : baudCnt + 1'b1;
            if (state == START) bitCnt <= '0;
            else if (shiftBit)  bitCnt <= bitCnt + 1'b1;
            if (shiftBit) shiftReg <= {rxs, shiftReg[7:1]};
        end
    end

    // Line assembler: newest character always lands in the low byte (right-justified).
    always_ff @(posedge clk) begin
        if (reset) begin
            lineBuf              <= '0;
            count                <= '0;
            asciiStringToDisplay <= '0;
            needToScroll         <= 1'b0;
            latchNewString       <= 1'b0;
            frameError           <= 1'b0;
        end else begin
            latchNewString <= 1'b0;
            frameError     <= stopLow;
            if (byteValid) begin
                if (shiftReg >= 8'h20 && shiftReg <= 8'h7E) begin
                    lineBuf <= {lineBuf[BUF_BITS-CH-1:0], shiftReg};
                    if (count != NW'(NUM_DIGITS)) count <= count + 1'b1;
                end else if (shiftReg == 8'h08) begin
                    if (count != '0) begin
                        lineBuf <= {{CH{1'b0}}, lineBuf[BUF_BITS-1:CH]};
                        count   <= count - 1'b1;
                    end
                end else if (shiftReg == 8'h0D || shiftReg == 8'h0A) begin
                    if (count != '0) begin
                        asciiStringToDisplay <= lineBuf;
                        needToScroll         <= (count > NW'(4));
                        latchNewString       <= 1'b1;
                        lineBuf              <= '0;
                        count                <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_ascii_line_receiver.sv
// Directed bench for uart_ascii_line_receiver at 10 clocks per UART bit.
module tb_uart_ascii_line_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [79:0] asciiStringToDisplay;
    logic        needToScroll;
    logic        latchNewString;
    logic        frameError;

    int unsigned testsRun = 0;
    int unsigned failCnt  = 0;
    int unsigned latchCnt = 0;
    int unsigned feCnt    = 0;
    int unsigned latchBase, feBase;

    uart_ascii_line_receiver #(
        .CLK_HZ(1_000_000),
        .BAUD(100_000),
        .NUM_DIGITS(10),
        .BITS_PER_ASCII_DIGIT(8),
        .BUF_BITS(80)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .asciiStringToDisplay(asciiStringToDisplay),
        .needToScroll(needToScroll),
        .latchNewString(latchNewString),
        .frameError(frameError)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output, sampled mid-cycle.
    always @(negedge clk) begin
        if (latchNewString === 1'b1) latchCnt++;
        if (frameError === 1'b1) feCnt++;
    end

    task automatic waitClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        waitClk(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            waitClk(10);
        end
        rx = stopBit;
        waitClk(10);
        rx = 1'b1;
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i], 1'b1);
    endtask

    task automatic mark();
        latchBase = latchCnt;
        feBase    = feCnt;
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        waitClk(3);
        check("reset_string", asciiStringToDisplay, 80'h0);
        check("reset_scroll", {79'h0, needToScroll}, 80'h0);
        check("reset_latch", {79'h0, latchNewString}, 80'h0);
        check("reset_ferr", {79'h0, frameError}, 80'h0);
        reset = 1'b0;
        waitClk(20);

        mark();
        sendStr("1234\r");
        waitClk(5);
        check("t1_latch", 80'(latchCnt - latchBase), 80'd1);
        check("t1_string", asciiStringToDisplay, 80'h31323334);
        check("t1_scroll", {79'h0, needToScroll}, 80'h0);

        mark();
        sendStr("HELLO\n");
        waitClk(5);
        check("t2_latch", 80'(latchCnt - latchBase), 80'd1);
        check("t2_string", asciiStringToDisplay, 80'h48454C4C4F);
        check("t2_scroll", {79'h0, needToScroll}, 80'h1);

        mark();
        sendStr("0123456789AB\r");
        waitClk(5);
        check("t3_latch", 80'(latchCnt - latchBase), 80'd1);
        check("t3_string", asciiStringToDisplay, 80'h32333435363738394142);
        check("t3_scroll", {79'h0, needToScroll}, 80'h1);

        mark();
        sendStr("12X");
        sendByte(8'h08, 1'b1);
        sendStr("3\r");
        waitClk(5);
        check("t4_latch", 80'(latchCnt - latchBase), 80'd1);
        check("t4_string", asciiStringToDisplay, 80'h313233);
        check("t4_scroll", {79'h0, needToScroll}, 80'h0);

        mark();
        sendByte(8'h08, 1'b1);
        sendStr("\r");
        waitClk(5);
        check("t4_empty_latch", 80'(latchCnt - latchBase), 80'd0);
        check("t4_empty_hold", asciiStringToDisplay, 80'h313233);

        mark();
        sendByte(8'h55, 1'b0);
        waitClk(30);
        sendStr("7\r\n");
        waitClk(5);
        check("t5_ferr", 80'(feCnt - feBase), 80'd1);
        check("t5_latch", 80'(latchCnt - latchBase), 80'd1);
        check("t5_string", asciiStringToDisplay, 80'h37);
        check("t5_scroll", {79'h0, needToScroll}, 80'h0);

        mark();
        rx = 1'b0;
        waitClk(3);
        rx = 1'b1;
        waitClk(30);
        sendStr("\r");
        waitClk(5);
        check("t5_glitch_ferr", 80'(feCnt - feBase), 80'd0);
        check("t5_glitch_latch", 80'(latchCnt - latchBase), 80'd0);

        // Leave "Q" in the working line, then reset halfway through data bit 4 of 'A'.
        sendStr("Q");
        waitClk(10);
        rx = 1'b0;
        waitClk(10);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0);
            waitClk(10);
        end
        rx = 1'b0;
        waitClk(5);
        reset = 1'b1;
        waitClk(2);
        check("t6_rst_string", asciiStringToDisplay, 80'h0);
        check("t6_rst_scroll", {79'h0, needToScroll}, 80'h0);
        check("t6_rst_latch", {79'h0, latchNewString}, 80'h0);
        reset = 1'b0;
        rx    = 1'b1;
        waitClk(30);
        mark();
        sendStr("9\r");
        waitClk(5);
        check("t6_latch", 80'(latchCnt - latchBase), 80'd1);
        check("t6_string", asciiStringToDisplay, 80'h39);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
        $finish;
    end

endmodule
